// File: rtl/fifo_word_packer.sv
// fifo_word_packer: read-side FIFO consumer that packs PACK consecutive
// DATA_WIDTH-bit entries into one wide word behind a valid/ready handshake.
// Partial words leave on flush_i. When the PACKER_TIMEOUT_EN macro is
// defined, they also leave after TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                       rd_clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]      fifo_rdata_i,
  output logic                       fifo_rd_en_o,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH*PACK-1:0] out_data_o,
  output logic [PACK-1:0]            out_keep_o
);

  localparam int unsigned CW = $clog2(PACK + 1);
  localparam int unsigned LW = $clog2(PACK);

  logic [CW-1:0]              cnt;
  logic                       pend;
  logic                       flush_req;
  logic [DATA_WIDTH*PACK-1:0] pack_q;

  logic [CW:0]                fill;
  logic                       full;
  logic                       out_free;
  logic                       xfer;
  logic                       flush_drop;
  logic                       tmo;
  logic [LW-1:0]              lane_idx;
  logic [DATA_WIDTH*PACK-1:0] word;
  logic [PACK-1:0]            keep;

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle;
  logic          idle_run;

  // Count idle cycles while a partial word sits with no capture in flight.
  always_comb begin
    idle_run = (cnt != '0) && !full && !pend && !flush_req;
    tmo      = idle_run && (idle == TW'(TIMEOUT - 1));
  end

  // Idle counter: restarts on any capture, transfer, or when not running.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if (pend || xfer || !idle_run) begin
      idle <= '0;
    end else begin
      idle <= idle + TW'(1);
    end
  end
`else
  // No idle timeout: partial words leave only on an explicit flush.
  always_comb begin
    tmo = 1'b0;
  end
`endif

  // Pop gating, transfer decision and the masked view of the pack register.
  always_comb begin
    fill         = {1'b0, cnt} + (CW + 1)'(pend);
    full         = (cnt == CW'(PACK));
    fifo_rd_en_o = rst_n && !fifo_empty_i && (fill < (CW + 1)'(PACK)) && !flush_req;
    out_free     = !out_valid_o || out_ready_i;
    // A full register implies no pop is in flight, so capture and transfer
    // never coincide.
    xfer         = out_free && (full || (flush_req && (cnt != '0) && !pend));
    flush_drop   = flush_req && (cnt == '0) && !pend;
    lane_idx     = cnt[LW-1:0];
    word         = '0;
    keep         = '0;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (k < 32'(cnt)) begin
        word[k*DATA_WIDTH +: DATA_WIDTH] = pack_q[k*DATA_WIDTH +: DATA_WIDTH];
        keep[k]                          = 1'b1;
      end
    end
  end

  // Pack register, fill count, flush latch and output register.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pend        <= 1'b0;
      flush_req   <= 1'b0;
      pack_q      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_keep_o  <= '0;
    end else begin
      pend <= fifo_rd_en_o;

      if (pend) begin
        pack_q[lane_idx*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata_i;
        cnt <= cnt + CW'(1);
      end else if (xfer) begin
        cnt <= '0;
      end

      if (flush_i || tmo) begin
        flush_req <= 1'b1;
      end else if (xfer || flush_drop) begin
        flush_req <= 1'b0;
      end

      if (xfer) begin
        out_valid_o <= 1'b1;
        out_data_o  <= word;
        out_keep_o  <= keep;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
